alu_seq_exec: RTL
=================

# alu_seq_exec

Multi-cycle execute unit that consumes the 4-bit `alu_op` code produced by ALU control and returns a 32-bit result. Single-cycle ops (AND/OR/XOR/ADD/SUB/SLT) finish in one cycle; shifts iterate one bit per cycle, and the optional multiply uses a 32-step shift-add. It sits between decode and writeback, with a valid/ready handshake on both sides so the core can stall on long ops.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operands and op presented.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `alu_op`  in  4  operation code from ALU control.
- `op_a`, `op_b`  in  32  operands; `op_b[4:0]` is the shift amount for shifts.
- `out_valid`  out  1  `result`, `zero` and `err` are valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  32  operation result.
- `zero`  out  1  high when `result == 0`.
- `err`  out  1  unsupported `alu_op`.

## Operation
- Op codes:
  - 0000 AND, 0001 OR, 0011 XOR, 0010 ADD, 0110 SUB.
  - 0111 SLT (signed; result 1 or 0).
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1100 MUL (low 32 bits, unsigned/signed agnostic).
  - Any other code: `result`=0, `err`=1.
- Arithmetic wraps mod 2^32; no overflow flag. SLT compares the true signed values, so overflow cannot flip it.
- States and transitions:
  - IDLE: `in_ready`=1. On `in_valid`, capture `op_a`, `op_b`, `alu_op`, then:
    - single-cycle or illegal op → DONE;
    - shift with shamt>0 → SHIFT, counter = shamt;
    - shift with shamt=0 → DONE, result = `op_a`;
    - MUL → MUL, counter = 32.
  - SHIFT: shift the accumulator one bit per cycle (SRA replicates bit 31) and decrement the counter. Go to DONE when the counter hits 0.
  - MUL: if multiplier bit0 is set, add the multiplicand into the product; shift the multiplicand left and the multiplier right; decrement the counter. Go to DONE at 0.
  - DONE: `out_valid`=1. Outputs are held stable until `out_ready`; on `out_ready` go to IDLE.
- `in_valid` is ignored outside IDLE. Input operands may change freely after acceptance.
- `zero` and `err` are registered alongside `result`.

## Timing
- Reset values: `in_ready`=0 during the reset cycle, then 1 in IDLE. `out_valid`=0, `result`=0, `zero`=0, `err`=0. State is IDLE and the counter is 0.
- Accept happens on the edge N where `in_valid && in_ready`.
- Latency to the first cycle with `out_valid`=1:
  - single-cycle op: N+1;
  - shift by k>0: N+1+k;
  - shift by 0: N+1;
  - MUL: N+33.
- If `out_ready` is already high when `out_valid` rises, the result is taken that cycle, and `in_ready` returns the following cycle. Minimum issue interval is therefore 2 cycles.
- `out_ready` low keeps DONE indefinitely; no data loss.
- `rst` asserted in any state takes effect at the next edge: the in-flight op is dropped and all outputs go to their reset values.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL state and the 1100 op are built as above.
- Not defined: no MUL state or multiplier registers. Op 1100 behaves as illegal: `result`=0, `err`=1, 1-cycle latency.

## Structure
- Package `alu_pkg`:
  - `XLEN` constant;
  - `alu_op_e` enum holding the op codes above;
  - `exec_state_e` enum {IDLE, SHIFT, MUL, DONE};
  - helper constant `SHAMT_W`=5.
- Sub-module `alu_comb`: purely combinational single-cycle ops (AND/OR/XOR/ADD/SUB/SLT plus the illegal-op flag). `alu_seq_exec` owns the FSM, counter, shift/multiply accumulators and output registers.

## Test plan
- ADD 0x00000005 + 0xFFFFFFFF, `out_ready`=1 → `result`=0x00000004 at N+1, `zero`=0. Then SUB 7-7 → `result`=0, `zero`=1.
- SRA 0x80000000 by 4 → `out_valid` at N+5, `result`=0xF8000000. SLL 0x1 by 0 → `result`=0x1 at N+1.
- SLT 0x80000000 < 0x00000001 → `result`=1. Swapped operands → 0. Op 0101 → `result`=0, `err`=1.
- MUL 0x0000FFFF × 0x00010001 with macro defined → `result`=0xFFFFFFFF at N+33. Without the macro → `err`=1 at N+1.
- Hold `out_ready`=0 for 10 cycles after an ADD → `result` stable, `in_ready`=0, a second `in_valid` is ignored. Release → back to IDLE next cycle.
- Assert `rst` at cycle 10 of a MUL → next cycle: IDLE, `out_valid`=0, `result`=0. A new ADD is then accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the sequential execute unit.
//   XLEN          datapath width (32 only)
//   SHAMT_W       width of the shift-amount field taken from op_b
//   CNT_W         iteration counter width (holds up to 32 multiply steps)
//   alu_op_e      4-bit operation codes from ALU control
//   exec_state_e  sequencer states
// Optional feature macro: ALU_SEQ_MUL_EN (enables the shift-add multiply).
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam int CNT_W   = SHAMT_W + 1;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SRA = 4'b1010,
        OP_MUL = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } exec_state_e;

    // Shift ops are the only iterative codes that are always built.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational single-cycle ALU ops.
//   op_i       4-bit operation code
//   a_i, b_i   operands
//   res_o      result for AND/OR/XOR/ADD/SUB/SLT (0 for every other code)
//   illegal_o  unsupported operation code flag
// Shift codes (and MUL when ALU_SEQ_MUL_EN is defined) are legal but are
// computed by the sequencer, so res_o is 0 for them.
module alu_comb
    import alu_pkg::*;
(
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] res_o,
    output logic            illegal_o
);

    always_comb begin
        res_o     = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_ADD: res_o = a_i + b_i;
            OP_SUB: res_o = a_i - b_i;
            // Signed compare on the true values, so wrap in a-b cannot flip it.
            OP_SLT: res_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLL, OP_SRL, OP_SRA: res_o = '0;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: res_o = '0;
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle execute unit with valid/ready on both sides.
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   alu_op, op_a, op_b    operation and operands (op_b[4:0] = shift amount)
//   out_valid / out_ready response handshake (outputs held until taken)
//   result, zero, err     registered result, result==0, unsupported op
// Single-cycle ops finish in one cycle, shifts move one bit per cycle and,
// with ALU_SEQ_MUL_EN defined, MUL runs a 32-step shift-add.
module alu_seq_exec
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            err
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    exec_state_e     state_q, state_d;
    alu_op_e         op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Shift accumulator, reused as the product register for MUL.
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            err_q, err_d;
`ifdef ALU_SEQ_MUL_EN
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] prod_nxt;
`endif

    logic [XLEN-1:0] comb_res;
    logic            comb_illegal;
    logic [XLEN-1:0] shift_nxt;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = op_b[SHAMT_W-1:0];

    alu_comb u_comb (
        .op_i      (alu_op),
        .a_i       (op_a),
        .b_i       (op_b),
        .res_o     (comb_res),
        .illegal_o (comb_illegal)
    );

    // One-bit step of the captured shift op; SRA replicates bit 31.
    always_comb begin
        case (op_q)
            OP_SLL:  shift_nxt = {acc_q[XLEN-2:0], 1'b0};
            OP_SRL:  shift_nxt = {1'b0, acc_q[XLEN-1:1]};
            default: shift_nxt = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    assign prod_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = alu_op_e'(alu_op);
                    if (is_shift_op(alu_op)) begin
                        if (shamt == '0) begin
                            state_d  = DONE;
                            result_d = op_a;
                            zero_d   = (op_a == '0);
                            err_d    = 1'b0;
                        end else begin
                            state_d = SHIFT;
                            cnt_d   = {1'b0, shamt};
                            acc_d   = op_a;
                        end
                    end
`ifdef ALU_SEQ_MUL_EN
                    else if (alu_op == OP_MUL) begin
                        state_d  = MUL;
                        cnt_d    = CNT_W'(XLEN);
                        acc_d    = '0;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                    end
`endif
                    else begin
                        state_d  = DONE;
                        result_d = comb_res;
                        zero_d   = (comb_res == '0);
                        err_d    = comb_illegal;
                    end
                end
            end
            SHIFT: begin
                acc_d = shift_nxt;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = DONE;
                    result_d = shift_nxt;
                    zero_d   = (shift_nxt == '0);
                    err_d    = 1'b0;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                acc_d    = prod_nxt;
                mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = DONE;
                    result_d = prod_nxt;
                    zero_d   = (prod_nxt == '0);
                    err_d    = 1'b0;
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_AND;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    // in_ready drops during the reset cycle even though state is already IDLE.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule
